// File: rtl/cu_seq_pkg.sv
// Shared encodings, microroutine entry points and the opcode dispatch map for
// the microsequencer.
package cu_seq_pkg;

    localparam logic [2:0] SEQ_HOLD     = 3'b000;
    localparam logic [2:0] SEQ_NEXT     = 3'b001;
    localparam logic [2:0] SEQ_DISPATCH = 3'b010;
    localparam logic [2:0] SEQ_FETCH    = 3'b011;
    localparam logic [2:0] SEQ_BR       = 3'b100;
    localparam logic [2:0] SEQ_CALL     = 3'b101;
    localparam logic [2:0] SEQ_RET      = 3'b110;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZF     = 2'b01;
    localparam logic [1:0] COND_NF     = 2'b10;
    localparam logic [1:0] COND_POS    = 2'b11;

    localparam logic [15:0] OPC_STORE  = 16'd1;
    localparam logic [15:0] OPC_LOAD   = 16'd2;
    localparam logic [15:0] OPC_ADD    = 16'd3;
    localparam logic [15:0] OPC_SUB    = 16'd4;
    localparam logic [15:0] OPC_JGZ    = 16'd5;
    localparam logic [15:0] OPC_JMP    = 16'd6;
    localparam logic [15:0] OPC_HALT   = 16'd7;
    localparam logic [15:0] OPC_MPY    = 16'd8;
    localparam logic [15:0] OPC_AND    = 16'd9;
    localparam logic [15:0] OPC_OR     = 16'd10;
    localparam logic [15:0] OPC_NOT    = 16'd11;
    localparam logic [15:0] OPC_SHIFTR = 16'd12;
    localparam logic [15:0] OPC_SHIFTL = 16'd13;

    localparam logic [7:0] UADDR_STORE  = 8'h07;
    localparam logic [7:0] UADDR_STOREH = 8'h23;
    localparam logic [7:0] UADDR_LOAD   = 8'h09;
    localparam logic [7:0] UADDR_ADD    = 8'h0B;
    localparam logic [7:0] UADDR_SUB    = 8'h0D;
    localparam logic [7:0] UADDR_MPY    = 8'h0F;
    localparam logic [7:0] UADDR_JUMP   = 8'h11;
    localparam logic [7:0] UADDR_HALT   = 8'h13;
    localparam logic [7:0] UADDR_AND    = 8'h15;
    localparam logic [7:0] UADDR_OR     = 8'h17;
    localparam logic [7:0] UADDR_NOT    = 8'h19;
    localparam logic [7:0] UADDR_SHIFTR = 8'h1B;
    localparam logic [7:0] UADDR_SHIFTL = 8'h1D;

    typedef struct packed {
        logic [7:0] addr;
        logic       to_fetch;
        logic       illegal;
    } disp_t;

    function automatic logic cond_true(input logic [1:0] sel, input logic zf, input logic nf);
        case (sel)
            COND_ALWAYS: return 1'b1;
            COND_ZF:     return zf;
            COND_NF:     return nf;
            default:     return !zf && !nf;
        endcase
    endfunction

    // to_fetch defers to the FETCH_ADDR parameter of the instantiating module
    function automatic disp_t dispatch_map(input logic [15:0] opcode, input logic zf,
                                           input logic nf, input logic mf);
        disp_t r;
        r = '{addr: '0, to_fetch: 1'b0, illegal: 1'b0};
        case (opcode)
            OPC_STORE:  r.addr = mf ? UADDR_STOREH : UADDR_STORE;
            OPC_LOAD:   r.addr = UADDR_LOAD;
            OPC_ADD:    r.addr = UADDR_ADD;
            OPC_SUB:    r.addr = UADDR_SUB;
            OPC_JGZ: begin
                r.addr     = UADDR_JUMP;
                r.to_fetch = zf || nf;
            end
            OPC_JMP:    r.addr = UADDR_JUMP;
            OPC_HALT:   r.addr = UADDR_HALT;
            OPC_MPY:    r.addr = UADDR_MPY;
            OPC_AND:    r.addr = UADDR_AND;
            OPC_OR:     r.addr = UADDR_OR;
            OPC_NOT:    r.addr = UADDR_NOT;
            OPC_SHIFTR: r.addr = UADDR_SHIFTR;
            OPC_SHIFTL: r.addr = UADDR_SHIFTL;
            default: begin
                r.to_fetch = 1'b1;
                r.illegal  = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cu_ustack.sv
// Micro-return LIFO: push/pop/flush with full, empty and occupancy outputs.
// Flush wins over push/pop; push when full and pop when empty are ignored.
module cu_ustack #(
    parameter int DEPTH = 4,
    parameter int W     = 7,
    localparam int AW   = $clog2(DEPTH),
    localparam int DW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_depth
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic [AW-1:0] wr_idx, rd_idx;

    assign o_full  = (depth_q == DW'(DEPTH));
    assign o_empty = (depth_q == '0);
    assign o_depth = depth_q;
    assign wr_idx  = AW'(depth_q);
    assign rd_idx  = AW'(depth_q - DW'(1));
    assign o_data  = mem_q[rd_idx];

    always_comb begin
        depth_d = depth_q;
        if (i_flush)
            depth_d = '0;
        else if (i_push && !o_full)
            depth_d = depth_q + DW'(1);
        else if (i_pop && !o_empty)
            depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            depth_q <= '0;
        else
            depth_q <= depth_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_flush && i_push && !o_full)
            mem_q[wr_idx] <= i_data;
    end

endmodule

// File: rtl/cu_microsequencer.sv
// Control address register and sequencing logic for the microprogrammed control unit.
// Define CU_USTACK_EN to build the micro-subroutine return stack (CALL/RET).
module cu_microsequencer #(
    parameter int CAR_W         = 7,
    parameter int OPC_W         = 4,
    parameter int STACK_DEPTH   = 4,
    parameter int FETCH_ADDR    = 0,
    parameter int INDIRECT_ADDR = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_stall,
    input  logic [2:0]                   i_seq_cmd,
    input  logic [1:0]                   i_cond_sel,
    input  logic [CAR_W-1:0]             i_branch_addr,
    input  logic [OPC_W-1:0]             i_opcode,
    input  logic                         i_indirect,
    input  logic                         i_flag_zf,
    input  logic                         i_flag_nf,
    input  logic                         i_flag_mf,
    output logic [CAR_W-1:0]             o_car_data,
    output logic                         o_indirect_done,
    output logic [$clog2(STACK_DEPTH):0] o_stack_depth,
    output logic                         o_stack_err,
    output logic                         o_illegal_op
);

    import cu_seq_pkg::*;

    localparam logic [CAR_W-1:0] FETCH_A    = CAR_W'(FETCH_ADDR);
    localparam logic [CAR_W-1:0] INDIRECT_A = CAR_W'(INDIRECT_ADDR);

    logic [CAR_W-1:0] car_q, car_d;
    logic             done_q, done_d;
    logic             ill_q, ill_d;
    logic [CAR_W-1:0] car_inc;
    disp_t            map_r;

    assign car_inc = car_q + CAR_W'(1);
    assign map_r   = dispatch_map(16'(i_opcode), i_flag_zf, i_flag_nf, i_flag_mf);

`ifdef CU_USTACK_EN
    logic             err_q, err_d;
    logic             push, pop, flush;
    logic             stk_full, stk_empty;
    logic [CAR_W-1:0] stk_top;

    cu_ustack #(
        .DEPTH (STACK_DEPTH),
        .W     (CAR_W)
    ) u_ustack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (flush),
        .i_data  (car_inc),
        .o_data  (stk_top),
        .o_full  (stk_full),
        .o_empty (stk_empty),
        .o_depth (o_stack_depth)
    );

    assign o_stack_err = err_q;
`else
    assign o_stack_depth = '0;
    assign o_stack_err   = 1'b0;
`endif

    always_comb begin
        car_d  = car_q;
        done_d = done_q;
        ill_d  = 1'b0;
`ifdef CU_USTACK_EN
        err_d  = err_q;
        push   = 1'b0;
        pop    = 1'b0;
        flush  = 1'b0;
`endif
        if (!i_stall) begin
            if (i_indirect && !done_q) begin
                car_d  = INDIRECT_A;
                done_d = 1'b1;
            end else begin
                case (i_seq_cmd)
                    SEQ_NEXT: car_d = car_inc;
                    SEQ_DISPATCH: begin
                        car_d = map_r.to_fetch ? FETCH_A : CAR_W'(map_r.addr);
                        ill_d = map_r.illegal;
                    end
                    SEQ_FETCH: begin
                        car_d  = FETCH_A;
                        done_d = 1'b0;
`ifdef CU_USTACK_EN
                        flush  = 1'b1;
`endif
                    end
                    SEQ_BR: car_d = cond_true(i_cond_sel, i_flag_zf, i_flag_nf) ? i_branch_addr : car_inc;
`ifdef CU_USTACK_EN
                    SEQ_CALL: begin
                        if (stk_full) begin
                            car_d = FETCH_A;
                            err_d = 1'b1;
                        end else begin
                            push  = 1'b1;
                            car_d = i_branch_addr;
                        end
                    end
                    SEQ_RET: begin
                        if (stk_empty) begin
                            car_d = FETCH_A;
                            err_d = 1'b1;
                        end else begin
                            pop   = 1'b1;
                            car_d = stk_top;
                        end
                    end
`else
                    SEQ_CALL: car_d = i_branch_addr;
                    SEQ_RET: begin
                        car_d  = FETCH_A;
                        done_d = 1'b0;
                    end
`endif
                    default: car_d = car_q;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            car_q  <= FETCH_A;
            done_q <= 1'b0;
            ill_q  <= 1'b0;
`ifdef CU_USTACK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            car_q  <= car_d;
            done_q <= done_d;
            ill_q  <= ill_d;
`ifdef CU_USTACK_EN
            err_q  <= err_d;
`endif
        end
    end

    assign o_car_data      = car_q;
    assign o_indirect_done = done_q;
    assign o_illegal_op    = ill_q;

endmodule

// File: tb/tb_cu_microsequencer.sv
// Scoreboard bench for cu_microsequencer: a behavioural model queues expected
// outputs per driven cycle, which are popped and compared after the clock edge.
module tb_cu_microsequencer;

    localparam logic [2:0] C_HOLD = 3'd0, C_NEXT = 3'd1, C_DISP = 3'd2, C_FETCH = 3'd3;
    localparam logic [2:0] C_BR = 3'd4, C_CALL = 3'd5, C_RET = 3'd6, C_RSV = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n, stall, ind, zf, nf, mf;
    logic [2:0] cmd;
    logic [1:0] cond;
    logic [6:0] baddr;
    logic [3:0] opc;
    logic [6:0] car;
    logic       done, serr, ill;
    logic [2:0] depth;

    always #5 clk = ~clk;

    cu_microsequencer #(
        .CAR_W         (7),
        .OPC_W         (4),
        .STACK_DEPTH   (4),
        .FETCH_ADDR    (0),
        .INDIRECT_ADDR (2)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_seq_cmd       (cmd),
        .i_cond_sel      (cond),
        .i_branch_addr   (baddr),
        .i_opcode        (opc),
        .i_indirect      (ind),
        .i_flag_zf       (zf),
        .i_flag_nf       (nf),
        .i_flag_mf       (mf),
        .o_car_data      (car),
        .o_indirect_done (done),
        .o_stack_depth   (depth),
        .o_stack_err     (serr),
        .o_illegal_op    (ill)
    );

    typedef struct {
        logic [6:0] car;
        logic       done;
        logic [2:0] depth;
        logic       err;
        logic       ill;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    logic [6:0] m_car, m_car_save;
    logic       m_done, m_err, m_ill;
    logic [6:0] m_stk[$];
    logic [6:0] dtab[16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic ok;
        if (!rst_n) begin
            m_car = 7'h00; m_done = 1'b0; m_err = 1'b0; m_ill = 1'b0;
            m_stk.delete();
        end else if (stall) begin
            m_ill = 1'b0;
        end else begin
            m_ill = 1'b0;
            if (ind && !m_done) begin
                m_car  = 7'h02;
                m_done = 1'b1;
            end else begin
                case (cmd)
                    C_NEXT: m_car = m_car + 7'd1;
                    C_DISP: begin
                        m_car = dtab[opc];
                        if (opc == 4'd1 && mf) m_car = 7'h23;
                        if (opc == 4'd5 && (zf || nf)) m_car = 7'h00;
                        if (opc == 4'd0 || opc >= 4'd14) m_ill = 1'b1;
                    end
                    C_FETCH: begin
                        m_car = 7'h00; m_done = 1'b0;
                        m_stk.delete();
                    end
                    C_BR: begin
                        case (cond)
                            2'b00:   ok = 1'b1;
                            2'b01:   ok = zf;
                            2'b10:   ok = nf;
                            default: ok = !zf && !nf;
                        endcase
                        m_car = ok ? baddr : m_car + 7'd1;
                    end
`ifdef CU_USTACK_EN
                    C_CALL: begin
                        if (m_stk.size() == 4) begin
                            m_car = 7'h00; m_err = 1'b1;
                        end else begin
                            m_stk.push_back(m_car + 7'd1);
                            m_car = baddr;
                        end
                    end
                    C_RET: begin
                        if (m_stk.size() == 0) begin
                            m_car = 7'h00; m_err = 1'b1;
                        end else begin
                            m_car = m_stk.pop_back();
                        end
                    end
`else
                    C_CALL: m_car = baddr;
                    C_RET: begin
                        m_car = 7'h00; m_done = 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic in, input logic [2:0] c,
                        input logic [1:0] cs, input logic [6:0] ba, input logic [3:0] op,
                        input logic z, input logic n, input logic m);
        exp_t e;
        @(negedge clk);
        rst_n = r; stall = s; ind = in; cmd = c; cond = cs; baddr = ba; opc = op;
        zf = z; nf = n; mf = m;
        model_step();
        e.car = m_car; e.done = m_done; e.depth = 3'(m_stk.size()); e.err = m_err; e.ill = m_ill;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_underrun", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("car",   car,   e.car);
            chk("done",  done,  e.done);
            chk("depth", depth, e.depth);
            chk("err",   serr,  e.err);
            chk("ill",   ill,   e.ill);
        end
    endtask

    task automatic go(input logic [2:0] c, input logic [6:0] ba);
        step(1'b1, 1'b0, 1'b0, c, 2'b00, ba, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic disp(input logic [3:0] op, input logic z, input logic n, input logic m);
        step(1'b1, 1'b0, 1'b0, C_DISP, 2'b00, 7'h00, op, z, n, m);
    endtask

    task automatic br(input logic [1:0] cs, input logic [6:0] ba, input logic z, input logic n);
        step(1'b1, 1'b0, 1'b0, C_BR, cs, ba, 4'd0, z, n, 1'b0);
    endtask

    initial begin
        dtab = '{7'h00, 7'h07, 7'h09, 7'h0B, 7'h0D, 7'h11, 7'h11, 7'h13,
                 7'h0F, 7'h15, 7'h17, 7'h19, 7'h1B, 7'h1D, 7'h00, 7'h00};
        m_car = 7'h00; m_done = 1'b0; m_err = 1'b0; m_ill = 1'b0;
        rst_n = 1'b0; stall = 1'b0; ind = 1'b0; cmd = C_HOLD; cond = 2'b00;
        baddr = 7'h00; opc = 4'd0; zf = 1'b0; nf = 1'b0; mf = 1'b0;

        step(1'b0, 1'b0, 1'b0, C_NEXT, 2'b00, 7'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, C_HOLD, 2'b00, 7'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_car", car, 7'h00);
        chk("rst_depth", depth, 3'd0);

        for (int i = 1; i <= 3; i++) begin
            go(C_NEXT, 7'h00);
            chk("next_seq", car, 7'(i));
        end
        br(2'b00, 7'h7F, 1'b0, 1'b0);
        go(C_NEXT, 7'h00);
        chk("next_wrap", car, 7'h00);

        go(C_NEXT, 7'h00);
        step(1'b1, 1'b0, 1'b1, C_NEXT, 2'b00, 7'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("ind_car", car, 7'h02);
        chk("ind_done", done, 1'b1);
        step(1'b1, 1'b0, 1'b1, C_NEXT, 2'b00, 7'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("ind_once", car, 7'h03);
        go(C_FETCH, 7'h00);
        chk("fetch_done", done, 1'b0);

        disp(4'd5, 1'b0, 1'b0, 1'b0);
        chk("jgz_taken", car, 7'h11);
        disp(4'd5, 1'b1, 1'b0, 1'b0);
        chk("jgz_zf", car, 7'h00);
        disp(4'd1, 1'b0, 1'b0, 1'b1);
        chk("storeh", car, 7'h23);
        disp(4'd14, 1'b0, 1'b0, 1'b0);
        chk("illegal_pulse", ill, 1'b1);
        go(C_HOLD, 7'h00);
        chk("illegal_clear", ill, 1'b0);
        for (int op = 0; op < 16; op++) begin
            disp(4'(op), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            go(C_FETCH, 7'h00);
        end

        br(2'b00, 7'h10, 1'b0, 1'b0);
        go(C_CALL, 7'h40);
        chk("call_car", car, 7'h40);
        go(C_RET, 7'h00);
`ifdef CU_USTACK_EN
        chk("ret_car", car, 7'h11);
`else
        chk("ret_fetch", car, 7'h00);
`endif
        go(C_FETCH, 7'h00);
        for (int i = 0; i < 5; i++) go(C_CALL, 7'(7'h40 + 4 * i));
`ifdef CU_USTACK_EN
        chk("ovf_car", car, 7'h00);
        chk("ovf_err", serr, 1'b1);
        chk("ovf_depth", depth, 3'd4);
`endif
        for (int i = 0; i < 5; i++) go(C_RET, 7'h00);

        br(2'b00, 7'h20, 1'b0, 1'b0);
        br(2'b01, 7'h55, 1'b0, 1'b0);
        chk("br_zf0", car, 7'h21);
        br(2'b01, 7'h55, 1'b1, 1'b0);
        chk("br_zf1", car, 7'h55);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'b00,
                 7'h33, 4'd14, 1'b0, 1'b0, 1'b0);
            chk("stall_freeze", car, 7'h55);
        end
        br(2'b10, 7'h66, 1'b0, 1'b1);
        br(2'b11, 7'h12, 1'b1, 1'b0);
        br(2'b11, 7'h12, 1'b0, 1'b0);

        go(C_FETCH, 7'h00);
        go(C_CALL, 7'h30);
        go(C_CALL, 7'h38);
        step(1'b0, 1'b0, 1'b0, C_CALL, 2'b00, 7'h50, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_car", car, 7'h00);
        chk("rst_mid_err", serr, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cu_microsequencer.md
Name: cu_microsequencer

Overview:
- Parametrised next-generation control address register and sequencing logic for the microprogrammed control unit.
- Generalises the fixed 7-bit CAR with a 2-bit command into:
  - a configurable-width CAR;
  - a 3-bit sequencing command;
  - conditional micro-branches;
  - a micro-subroutine return stack;
  - stall support;
  - illegal-opcode detection.
- Feeds the control memory address; consumes IR opcode/indirect bit and ALU flags.

Parameters:
- CAR_W, 7, control address width.
- OPC_W, 4, opcode field width.
- STACK_DEPTH, 4, micro-return stack entries (power of two, >=2).
- FETCH_ADDR, 0, fetch microroutine entry.
- INDIRECT_ADDR, 2, indirect-cycle microroutine entry.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_stall  input  1  freeze all state this cycle
- i_seq_cmd  input  3  sequencing command from current microword
- i_cond_sel  input  2  branch condition: 00 always, 01 ZF, 10 NF, 11 positive (!ZF & !NF)
- i_branch_addr  input  CAR_W  target for BR/CALL
- i_opcode  input  OPC_W  IR opcode field
- i_indirect  input  1  IR indirect-addressing bit
- i_flag_zf  input  1  zero flag
- i_flag_nf  input  1  negative flag
- i_flag_mf  input  1  multiply-high flag (selects STORE+STOREH path)
- o_car_data  output  CAR_W  current control address
- o_indirect_done  output  1  indirect cycle already taken for this instruction
- o_stack_depth  output  $clog2(STACK_DEPTH)+1  occupied stack entries
- o_stack_err  output  1  sticky overflow/underflow flag
- o_illegal_op  output  1  one-cycle pulse on dispatch of unmapped opcode

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - o_car_data=FETCH_ADDR; stack empty; o_stack_depth=0.
  - o_indirect_done=0; o_stack_err=0; o_illegal_op=0.
- Priority each posedge: reset > stall > indirect > command.
- Stall: all registers hold; o_illegal_op forced 0.
- Indirect:
  - If i_indirect=1 and o_indirect_done=0, CAR<=INDIRECT_ADDR and o_indirect_done<=1.
  - i_seq_cmd is ignored that cycle.
- Commands (i_seq_cmd):
  - 000 HOLD: CAR unchanged.
  - 001 NEXT: CAR<=CAR+1, wrapping modulo 2^CAR_W.
  - 010 DISPATCH: CAR<=map(i_opcode):
    - 1 STORE: 0x07, or 0x23 if MF.
    - 2 LOAD: 0x09.
    - 3 ADD: 0x0B.
    - 4 SUB: 0x0D.
    - 5 JGZ: 0x11 if !ZF & !NF, else FETCH_ADDR.
    - 6 JMP: 0x11.
    - 7 HALT: 0x13.
    - 8 MPY: 0x0F.
    - 9 AND: 0x15.
    - 10 OR: 0x17.
    - 11 NOT: 0x19.
    - 12 SHIFTR: 0x1B.
    - 13 SHIFTL: 0x1D.
    - Others: CAR<=FETCH_ADDR and o_illegal_op=1 for one cycle.
  - 011 FETCH: CAR<=FETCH_ADDR; o_indirect_done<=0; stack flushed (depth 0). o_stack_err is not cleared.
  - 100 BR: if condition true, CAR<=i_branch_addr; else CAR<=CAR+1.
  - 101 CALL:
    - Push CAR+1; CAR<=i_branch_addr.
    - If stack full: no push, CAR<=FETCH_ADDR, o_stack_err<=1.
  - 110 RET:
    - Pop into CAR.
    - If stack empty: CAR<=FETCH_ADDR, o_stack_err<=1.
  - 111: reserved, behaves as HOLD.
- Latency: o_car_data is registered; a command applied in cycle n is visible in cycle n+1.
- Flags are sampled in the same cycle as DISPATCH or BR.
- o_stack_err is sticky until reset.
- Upper bits of the map constants are zero-extended to CAR_W.

Optional Feature:
- CU_USTACK_EN defined:
  - Stack, CALL and RET behave as above.
- CU_USTACK_EN undefined:
  - No stack storage.
  - CALL = unconditional jump to i_branch_addr.
  - RET = FETCH behaviour.
  - o_stack_depth and o_stack_err tied to 0.

Decomposition:
- Package cu_seq_pkg holds:
  - SEQ_* command encodings;
  - COND_* encodings;
  - opcode localparams;
  - microroutine entry address constants;
  - a dispatch-map function (opcode, flags) -> {addr, illegal}.
- One sub-module, cu_ustack: a LIFO with push/pop/flush, full/empty and depth outputs, instantiated under CU_USTACK_EN.

Test Plan:
- Reset then NEXT x3 -> CAR 0,1,2,3; with CAR=0x7F, NEXT -> 0x00 (wrap).
- i_indirect=1, cmd=NEXT from CAR=1 -> CAR=0x02, done=1.
  - Next cycle, NEXT -> 0x03.
  - FETCH -> 0x00, done=0.
- DISPATCH opcode 5:
  - ZF=0, NF=0 -> 0x11.
  - ZF=1 -> 0x00.
  - Opcode 1 with MF=1 -> 0x23.
  - Opcode 14 -> 0x00 with o_illegal_op pulse.
- CALL 0x40 from CAR=0x10 -> 0x40, depth 1; RET -> 0x11, depth 0.
  - 5 nested CALLs (depth 4) -> 5th gives CAR=0x00, o_stack_err=1.
- BR cond=01 with ZF=0 from 0x20 -> 0x21; with ZF=1 -> i_branch_addr.
  - i_stall=1 for 3 cycles -> CAR frozen.
- Reset asserted mid-CALL chain -> CAR=0, depth 0, err cleared.
